// File: rtl/alu_vector_checker.sv
// Purpose : on-chip self-check engine; fetches packed vectors from a sync ROM, drives the ALU, compares results.
// Latency : 3+ALU_LATENCY cycles per vector; NUM_VECTORS*(3+ALU_LATENCY)+1 cycles from first FETCH to done.
// Backpr. : none; start is accepted only in IDLE, and ROM/ALU are assumed always ready.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   start             - one-cycle pulse, begins a run from IDLE
//   busy / done       - busy outside IDLE; done pulses for one cycle at run end
//   pass              - run had zero mismatches; valid from done until next start
//   vec_rd_en/addr    - ROM read strobe and index; vec_data returns the following cycle
//   vec_data          - {A[28:21], B[20:13], Sel[12:9], exp_out[8:1], exp_carry[0]}
//   alu_a/b/sel       - registered ALU operands, held after a run
//   alu_out/carry     - ALU result
//   err_count         - saturating mismatch count for this run
//   first_fail_*      - index of the first mismatching vector
module alu_vector_checker #(
    parameter int NUM_VECTORS = 16,
    parameter int ADDR_W      = 4,
    parameter int ALU_LATENCY = 1,
    parameter int ERR_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              vec_rd_en,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [28:0]       vec_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_sel,
    input  logic [7:0]        alu_out,
    input  logic              alu_carry,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx
);

    localparam int CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ALU_LATENCY);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_APPLY,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [7:0]        exp_out_q;
    logic              exp_carry_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              rd_en_q;
    logic [7:0]        alu_a_q;
    logic [7:0]        alu_b_q;
    logic [3:0]        alu_sel_q;
    logic [ERR_W-1:0]  err_q;
    logic              ff_vld_q;
    logic [ADDR_W-1:0] ff_idx_q;

    logic              mismatch;
    logic [ERR_W-1:0]  err_d;

    // The mismatch flag defaults to 1 and is cleared only on a definite
    // equality, so an unknown compare result in simulation counts as a miss.
    always_comb begin
        mismatch = 1'b1;
        if ({alu_carry, alu_out} == {exp_carry_q, exp_out_q}) begin
            mismatch = 1'b0;
        end
        err_d = err_q;
        if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            exp_out_q   <= '0;
            exp_carry_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            err_q       <= '0;
            ff_vld_q    <= 1'b0;
            ff_idx_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_FETCH;
                        idx_q    <= '0;
                        err_q    <= '0;
                        ff_vld_q <= 1'b0;
                        ff_idx_q <= '0;
                        pass_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    alu_a_q     <= vec_data[28:21];
                    alu_b_q     <= vec_data[20:13];
                    alu_sel_q   <= vec_data[12:9];
                    exp_out_q   <= vec_data[8:1];
                    exp_carry_q <= vec_data[0];
                    wait_cnt_q  <= CNT_LOAD;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == CNT_ONE) begin
                        state_q <= S_CHECK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_ONE;
                    end
                end
                S_CHECK: begin
                    err_q <= err_d;
                    if (mismatch && !ff_vld_q) begin
                        ff_vld_q <= 1'b1;
                        ff_idx_q <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        // pass/done become visible together in the DONE cycle
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        rd_en_q <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign vec_rd_en        = rd_en_q;
    assign vec_addr         = idx_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_sel          = alu_sel_q;
    assign err_count        = err_q;
    assign first_fail_valid = ff_vld_q;
    assign first_fail_idx   = ff_idx_q;

endmodule
